fp_div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one fp_division core (IEEE-754 single-precision divider, 2-cycle registered latency) among N requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the core. In-flight operations are tracked with a tag pipeline, and results return in issue order through a credit-protected response FIFO. It sits between client blocks and the single fp_division instance.

---
 rtl/fp_div_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fp_div_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one fixed-latency
//            fp_division core among N requesters. One issue per cycle;
//            in-flight ops tracked by a tag pipeline; results return in
//            issue order through a credit-protected FWFT response FIFO.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            req_valid/ready     - per-requester handshake (ready one-hot/0)
//            req_a/req_b         - packed operands, requester i at [32i+:32]
//            core_a/core_b       - operands to the divider core
//            core_c              - divider result, CORE_LAT cycles later
//            rsp_valid/ready     - response FIFO head handshake
//            rsp_id/data/dz      - head requester index, quotient, div-by-0
//            inflight            - ops issued but not yet in the FIFO
// Options  : FP_DIV_ARB_ZERO_CHECK_EN - flag zero divisors and return a
//            signed infinity with rsp_dz = 1 (rsp_dz tied 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_arbiter #(
    parameter int N         = 4,
    parameter int CORE_LAT  = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   req_valid,
    output logic [N-1:0]                   req_ready,
    input  logic [32*N-1:0]                req_a,
    input  logic [32*N-1:0]                req_b,
    output logic [31:0]                    core_a,
    output logic [31:0]                    core_b,
    input  logic [31:0]                    core_c,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(N)-1:0]           rsp_id,
    output logic [31:0]                    rsp_data,
    output logic                           rsp_dz,
    output logic [$clog2(RSP_DEPTH+1)-1:0] inflight
);

    localparam int c_IDW = $clog2(N);
    localparam int c_CW  = $clog2(RSP_DEPTH + 1);
    localparam int c_PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [c_IDW-1:0]    r_rr;
    logic [CORE_LAT-1:0] r_tag_vld;
    logic [c_IDW-1:0]    r_tag_id [CORE_LAT];
    logic [c_CW-1:0]     r_inflight;
    logic [c_CW-1:0]     r_count;
    logic [c_PW-1:0]     r_wr;
    logic [c_PW-1:0]     r_rd;
    logic [c_IDW-1:0]    r_mem_id   [RSP_DEPTH];
    logic [31:0]         r_mem_data [RSP_DEPTH];

    logic                w_found;
    logic [c_IDW-1:0]    w_grant;
    logic                w_can_issue;
    logic                w_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_rsp_valid;
    logic [31:0]         w_a_sel;
    logic [31:0]         w_b_sel;
    logic [31:0]         w_push_data;

    // Credit check uses only registered occupancy, so a pop this cycle frees
    // its slot no earlier than next cycle.
    assign w_can_issue = ({1'b0, r_count} + {1'b0, r_inflight}) < (c_CW + 1)'(RSP_DEPTH);

    // First requesting index at or above the rr pointer, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_valid[(int'(r_rr) + k) % N]) begin
                w_found = 1'b1;
                w_grant = c_IDW'((int'(r_rr) + k) % N);
            end
        end
    end

    assign w_fire    = w_found & w_can_issue & ~rst;
    assign req_ready = w_fire ? (N'(1) << w_grant) : '0;
    assign w_a_sel   = req_a[int'(w_grant) * 32 +: 32];
    assign w_b_sel   = req_b[int'(w_grant) * 32 +: 32];
    assign core_a    = w_fire ? w_a_sel : 32'h0;
    assign core_b    = w_fire ? w_b_sel : 32'h0;

    // The last tag stage lines up with the cycle core_c holds that op's result.
    assign w_push      = r_tag_vld[CORE_LAT-1];
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & rsp_ready;

`ifdef FP_DIV_ARB_ZERO_CHECK_EN
    logic [CORE_LAT-1:0] r_tag_dz;
    logic [CORE_LAT-1:0] r_tag_sgn;
    logic                r_mem_dz [RSP_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_dz  <= '0;
            r_tag_sgn <= '0;
        end else begin
            for (int i = CORE_LAT - 1; i > 0; i--) begin
                r_tag_dz[i]  <= r_tag_dz[i-1];
                r_tag_sgn[i] <= r_tag_sgn[i-1];
            end
            r_tag_dz[0]  <= w_fire & (w_b_sel[30:0] == 31'h0);
            r_tag_sgn[0] <= w_a_sel[31] ^ w_b_sel[31];
        end
    end

    // Zero-divisor ops still occupy a core slot so ordering is untouched;
    // only the stored result is substituted.
    assign w_push_data = r_tag_dz[CORE_LAT-1] ? {r_tag_sgn[CORE_LAT-1], 8'hFF, 23'h0} : core_c;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dz[r_wr] <= r_tag_dz[CORE_LAT-1];
        end
    end

    assign rsp_dz = w_rsp_valid ? r_mem_dz[r_rd] : 1'b0;
`else
    assign w_push_data = core_c;
    assign rsp_dz      = 1'b0;
`endif

    // Tag pipeline, rr pointer and occupancy counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr       <= '0;
            r_tag_vld  <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            for (int i = CORE_LAT - 1; i > 0; i--) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            r_tag_vld[0] <= w_fire;
            r_tag_id[0]  <= w_grant;
            if (w_fire) begin
                r_rr <= (int'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;
            end
            r_inflight <= r_inflight + c_CW'(w_fire) - c_CW'(w_push);
            r_count    <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            if (w_push) begin
                r_wr <= (r_wr == c_PW'(RSP_DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_PW'(RSP_DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr]   <= r_tag_id[CORE_LAT-1];
            r_mem_data[r_wr] <= w_push_data;
        end
    end

    assign rsp_valid = w_rsp_valid;
    assign rsp_id    = w_rsp_valid ? r_mem_id[r_rd] : '0;
    assign rsp_data  = w_rsp_valid ? r_mem_data[r_rd] : 32'h0;
    assign inflight  = r_inflight;

    // The credit rule must make a push into a full FIFO without a pop impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == c_CW'(RSP_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_arbiter
// Purpose  : Self-checking bench for fp_div_arbiter. A queue-based model of
//            the arbiter and a behavioural stand-in for the divider core are
//            compared against the DUT every cycle, plus directed literal
//            checks for latency, grant order, credit stall and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_arbiter;

    localparam int N         = 4;
    localparam int CORE_LAT  = 2;
    localparam int RSP_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [31:0]     core_a;
    logic [31:0]     core_b;
    logic [31:0]     core_c;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_dz;
    logic [2:0]      inflight;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_div_arbiter #(.N(N), .CORE_LAT(CORE_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .core_a(core_a), .core_b(core_b), .core_c(core_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
        .inflight(inflight)
    );

    // Divider stand-in: exact quotients for the directed operands, a fixed
    // scramble otherwise (the arbiter only forwards core_c).
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
        return a ^ {b[7:0], b[31:8]};
    endfunction

    logic [31:0] c1 = 32'h0;
    logic [31:0] c2 = 32'h0;
    always @(posedge clk) begin
        c1 <= core_fn(core_a, core_b);
        c2 <= c1;
    end
    assign core_c = c2;

    // ---------------- model ----------------
    typedef struct { int id; logic [31:0] a; logic [31:0] b; int ret; } op_t;
    typedef struct { int id; logic [31:0] d; logic dz; } rsp_t;
    op_t  infl[$];
    rsp_t fifo[$];
    int   m_rr = 0;
    int   cyc  = 0;

    function automatic int exp_grant();
        int idx;
        if (rst) return -1;
        if (fifo.size() + infl.size() >= RSP_DEPTH) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int   g;
        op_t  o;
        rsp_t r;
        if (rst) begin
            infl.delete();
            fifo.delete();
            m_rr = 0;
        end else begin
            g = exp_grant();
            if (fifo.size() > 0 && rsp_ready) void'(fifo.pop_front());
            if (infl.size() > 0 && infl[0].ret == cyc) begin
                o    = infl.pop_front();
                r.id = o.id;
                r.d  = core_fn(o.a, o.b);
                r.dz = 1'b0;
`ifdef FP_DIV_ARB_ZERO_CHECK_EN
                if (o.b[30:0] == 31'h0) begin
                    r.d  = {o.a[31] ^ o.b[31], 8'hFF, 23'h0};
                    r.dz = 1'b1;
                end
`endif
                fifo.push_back(r);
            end
            if (g >= 0) begin
                o.id  = g;
                o.a   = req_a[32*g +: 32];
                o.b   = req_b[32*g +: 32];
                o.ret = cyc + CORE_LAT;
                infl.push_back(o);
                m_rr = (g + 1) % N;
            end
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int          g;
        logic [31:0] er;
        logic [31:0] ea;
        logic [31:0] eb;
        g  = exp_grant();
        er = (g >= 0) ? (32'h1 << g) : 32'h0;
        ea = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
        eb = (g >= 0) ? req_b[32*g +: 32] : 32'h0;
        chk("req_ready", 32'(req_ready), er);
        chk("core_a", core_a, ea);
        chk("core_b", core_b, eb);
        chk("rsp_valid", 32'(rsp_valid), 32'(fifo.size() > 0));
        if (fifo.size() > 0) begin
            chk("rsp_id", 32'(rsp_id), 32'(fifo[0].id));
            chk("rsp_data", rsp_data, fifo[0].d);
            chk("rsp_dz", 32'(rsp_dz), 32'(fifo[0].dz));
        end else begin
            chk("rsp_id_idle", 32'(rsp_id), 32'h0);
            chk("rsp_data_idle", rsp_data, 32'h0);
            chk("rsp_dz_idle", 32'(rsp_dz), 32'h0);
        end
        chk("inflight", 32'(inflight), 32'(infl.size()));
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = v;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic wait_grant(input int i, output int t);
        t = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            total++;
            bad++;
            $display("FAIL wait_grant%0d: got no grant, expected one within 20 cycles", i);
        end
    endtask

    initial begin
        int t;
        int hs;
        int pk;
        int seen;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_inflight", 32'(inflight), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);

        // Single op from requester 0: 6.0 / 2.0
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h40C00000, 32'h40000000);
        wait_grant(0, t);
        pk = int'(inflight);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            if (int'(inflight) > pk) pk = int'(inflight);
            if (cyc < t + 3) chk("single_early_rsp", 32'(rsp_valid), 32'h0);
        end
        chk("single_latency_cycle", 32'(cyc), 32'(t + 3));
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h0);
        chk("single_rsp_data", rsp_data, 32'h40400000);
        chk("single_inflight_peak", 32'(pk), 32'h1);

        // All four streaming 1.0/1.0; rr pointer sits at 1 after the single op
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h3F800000, 32'h3F800000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("grant_seq", 32'(req_ready), 32'h1 << ((1 + k) % 4));
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Credit stall: consumer blocked, requesters 1 and 2 streaming
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'h41000000, 32'h3F000000);
        set_req(2, 1'b1, 32'h42000000, 32'h40800000);
        hs = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready != '0) hs++;
        end
        chk("stall_handshakes", 32'(hs), 32'h4);
        chk("stall_req_ready", 32'(req_ready), 32'h0);
        chk("stall_inflight", 32'(inflight), 32'h0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("credit_pop_cycle", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("credit_reopen", 32'(req_ready != '0), 32'h1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Reset with two ops in flight
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h40C00000, 32'h40000000);
        set_req(3, 1'b1, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("pre_reset_inflight", 32'(inflight), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_core_a", core_a, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("post_reset_no_rsp", 32'(seen), 32'h0);

        // Zero divisor followed by a normal op
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'hC0000000, 32'h80000000);
        set_req(1, 1'b1, 32'h40C00000, 32'h40000000);
        @(negedge clk);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        t = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t = n;
                break;
            end
        end
        chk("dz_rsp_arrived", 32'(t >= 0), 32'h1);
        chk("dz_rsp_id", 32'(rsp_id), 32'h0);
`ifdef FP_DIV_ARB_ZERO_CHECK_EN
        chk("dz_rsp_data", rsp_data, 32'h7F800000);
        chk("dz_rsp_flag", 32'(rsp_dz), 32'h1);
`else
        chk("dz_off_rsp_flag", 32'(rsp_dz), 32'h0);
`endif
        @(negedge clk);
        chk("after_dz_id", 32'(rsp_id), 32'h1);
        chk("after_dz_data", rsp_data, 32'h40400000);
        chk("after_dz_flag", 32'(rsp_dz), 32'h0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
